// File: rtl/treasure_classifier_pkg.sv
// Shared encodings for the treasure classifier and the serial transmitter:
// result codes, RGB332 field helpers, color thresholds and FSM states.
package treasure_classifier_pkg;

    localparam logic [1:0] COLOR_NONE     = 2'b00;
    localparam logic [1:0] COLOR_RED      = 2'b10;
    localparam logic [1:0] COLOR_BLUE     = 2'b11;

    localparam logic [1:0] SHAPE_NONE     = 2'b00;
    localparam logic [1:0] SHAPE_SQUARE   = 2'b01;
    localparam logic [1:0] SHAPE_TRIANGLE = 2'b10;
    localparam logic [1:0] SHAPE_DIAMOND  = 2'b11;

    localparam logic [2:0] RED_R_MIN  = 3'd5;
    localparam logic [1:0] RED_B_MAX  = 2'd1;
    localparam logic [1:0] BLUE_B_MIN = 2'd2;
    localparam logic [2:0] BLUE_R_MAX = 3'd2;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_ACCUM,
        ST_COLOR,
        ST_SHAPE,
        ST_PUBLISH,
        ST_WAIT_LOW
    } state_t;

    function automatic logic [2:0] pix_r(input logic [7:0] p);
        return p[7:5];
    endfunction

    function automatic logic [2:0] pix_g(input logic [7:0] p);
        return p[4:2];
    endfunction

    function automatic logic [1:0] pix_b(input logic [7:0] p);
        return p[1:0];
    endfunction

endpackage

// File: rtl/treasure_classifier_pixel_color_filter.sv
// Combinational RGB332 pixel classifier: flags strongly red or strongly blue pixels.
module pixel_color_filter
    import treasure_classifier_pkg::*;
(
    input  logic [7:0] pixel_i,
    output logic       is_red_o,
    output logic       is_blue_o
);

    logic [2:0] r;
    logic [1:0] b;
    logic       unused_g;

    assign r         = pix_r(pixel_i);
    assign b         = pix_b(pixel_i);
    assign unused_g  = ^pix_g(pixel_i);

    assign is_red_o  = (r >= RED_R_MIN) && (b <= RED_B_MAX);
    assign is_blue_o = (b >= BLUE_B_MIN) && (r <= BLUE_R_MAX);

endmodule

// File: rtl/treasure_classifier.sv
// Per-frame red/blue pixel statistics, then color/shape decision published on
// registered outputs with a one-cycle RESULT_VALID strobe after VSYNC rises.
module treasure_classifier
    import treasure_classifier_pkg::*;
#(
    parameter int WIDTH        = 176,
    parameter int HEIGHT       = 144,
    parameter int ROW_TOP      = 36,
    parameter int ROW_MID      = 72,
    parameter int ROW_BOT      = 108,
    parameter int COLOR_THRESH = 1000,
    parameter int SHAPE_TOL    = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       VSYNC,
    input  logic       HREF,
    input  logic       PIXEL_VALID,
    input  logic [7:0] PIXEL,
    output logic [1:0] TREASURE_COLOR,
    output logic [1:0] TREASURE_SHAPE,
    output logic       RESULT_VALID
);

    localparam logic [8:0]       WIDTH_C  = 9'(WIDTH);
    localparam logic [8:0]       HEIGHT_C = 9'(HEIGHT);
    localparam logic [14:0]      THRESH_C = 15'(COLOR_THRESH);
    localparam logic [8:0]       TOL_C    = 9'(SHAPE_TOL);
    localparam logic [2:0][7:0]  ROW_C    = {8'(ROW_BOT), 8'(ROW_MID), 8'(ROW_TOP)};

    state_t          state_q;
    logic            vsync_q, href_q;
    logic [7:0]      col_q, col_d, row_q, row_d;
    logic [14:0]     red_cnt_q, red_cnt_d, blue_cnt_q, blue_cnt_d;
    logic [2:0][7:0] red_w_q, red_w_d, blue_w_q, blue_w_d;
    logic [7:0]      wt_q, wm_q, wb_q;
    logic [1:0]      color_q, color_d, shape_d, shape_q;
    logic [1:0]      color_out_q, shape_out_q;
    logic            valid_q;

    logic            is_red, is_blue;
    logic            vs_rise, vs_fall, href_rise, href_fall;
    logic            clr, pix_cnt;
    logic [7:0]      col_eff;
    logic [2:0][7:0] sel_w;

    pixel_color_filter u_filter (
        .pixel_i   (PIXEL),
        .is_red_o  (is_red),
        .is_blue_o (is_blue)
    );

    assign vs_rise   = VSYNC & ~vsync_q;
    assign vs_fall   = ~VSYNC & vsync_q;
    assign href_rise = HREF & ~href_q;
    assign href_fall = ~HREF & href_q;
    assign clr       = vs_fall && (state_q == ST_SYNC || state_q == ST_WAIT_LOW);
    // A pixel arriving on the HREF rising edge belongs to column 0.
    assign col_eff   = href_rise ? 8'd0 : col_q;
    assign pix_cnt   = (state_q == ST_ACCUM) && PIXEL_VALID && HREF && !VSYNC &&
                       ({1'b0, col_eff} < WIDTH_C) && ({1'b0, row_q} < HEIGHT_C);

    always_comb begin
        col_d      = col_eff;
        row_d      = row_q;
        red_cnt_d  = red_cnt_q;
        blue_cnt_d = blue_cnt_q;
        red_w_d    = red_w_q;
        blue_w_d   = blue_w_q;
        if (pix_cnt)
            col_d = col_eff + 8'd1;
        if (href_fall && !VSYNC && row_q != 8'hFF)
            row_d = row_q + 8'd1;
        if (pix_cnt && is_red && red_cnt_q != '1)
            red_cnt_d = red_cnt_q + 15'd1;
        if (pix_cnt && is_blue && blue_cnt_q != '1)
            blue_cnt_d = blue_cnt_q + 15'd1;
        for (int i = 0; i < 3; i++) begin
            if (pix_cnt && row_q == ROW_C[i]) begin
                red_w_d[i]  = red_w_q[i] + {7'd0, is_red};
                blue_w_d[i] = blue_w_q[i] + {7'd0, is_blue};
            end
        end
        if (clr) begin
            col_d      = '0;
            row_d      = '0;
            red_cnt_d  = '0;
            blue_cnt_d = '0;
            red_w_d    = '0;
            blue_w_d   = '0;
        end
    end

    // Color decision; a red/blue tie falls through to blue.
    always_comb begin
        color_d = COLOR_NONE;
        sel_w   = red_w_q;
        if (red_cnt_q > blue_cnt_q && red_cnt_q >= THRESH_C) begin
            color_d = COLOR_RED;
        end else if (blue_cnt_q >= THRESH_C) begin
            color_d = COLOR_BLUE;
            sel_w   = blue_w_q;
        end
    end

    logic [8:0] t9, m9, b9, d_tb, d_mt;
    assign t9   = {1'b0, wt_q};
    assign m9   = {1'b0, wm_q};
    assign b9   = {1'b0, wb_q};
    assign d_tb = (t9 > b9) ? t9 - b9 : b9 - t9;
    assign d_mt = (m9 > t9) ? m9 - t9 : t9 - m9;

    always_comb begin
        shape_d = SHAPE_NONE;
        if (color_q == COLOR_NONE || wt_q == 8'd0 || wm_q == 8'd0 || wb_q == 8'd0)
            shape_d = SHAPE_NONE;
        else if (d_tb <= TOL_C && d_mt <= TOL_C)
            shape_d = SHAPE_SQUARE;
        else if (t9 + TOL_C < m9 && m9 + TOL_C < b9)
            shape_d = SHAPE_TRIANGLE;
        else if (m9 > t9 + TOL_C && m9 > b9 + TOL_C)
            shape_d = SHAPE_DIAMOND;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_SYNC;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            red_cnt_q   <= '0;
            blue_cnt_q  <= '0;
            red_w_q     <= '0;
            blue_w_q    <= '0;
            wt_q        <= '0;
            wm_q        <= '0;
            wb_q        <= '0;
            color_q     <= COLOR_NONE;
            shape_q     <= SHAPE_NONE;
            color_out_q <= COLOR_NONE;
            shape_out_q <= SHAPE_NONE;
            valid_q     <= 1'b0;
        end else begin
            vsync_q    <= VSYNC;
            href_q     <= HREF;
            col_q      <= col_d;
            row_q      <= row_d;
            red_cnt_q  <= red_cnt_d;
            blue_cnt_q <= blue_cnt_d;
            red_w_q    <= red_w_d;
            blue_w_q   <= blue_w_d;
            valid_q    <= 1'b0;
            case (state_q)
                ST_SYNC:     if (vs_fall) state_q <= ST_ACCUM;
                ST_ACCUM:    if (vs_rise) state_q <= ST_COLOR;
                ST_COLOR: begin
                    color_q <= color_d;
                    wt_q    <= sel_w[0];
                    wm_q    <= sel_w[1];
                    wb_q    <= sel_w[2];
                    state_q <= ST_SHAPE;
                end
                ST_SHAPE: begin
                    shape_q <= shape_d;
                    state_q <= ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    color_out_q <= color_q;
                    shape_out_q <= shape_q;
                    valid_q     <= 1'b1;
                    state_q     <= ST_WAIT_LOW;
                end
                // A falling edge missed during COLOR..PUBLISH skips that frame.
                ST_WAIT_LOW: if (vs_fall) state_q <= ST_ACCUM;
                default:     state_q <= ST_SYNC;
            endcase
        end
    end

    assign TREASURE_COLOR = color_out_q;
    assign TREASURE_SHAPE = shape_out_q;
    assign RESULT_VALID   = valid_q;

endmodule

// File: tb/tb_treasure_classifier.sv
// Frame-level bench: directed shapes plus randomized frames, checked against a
// pixel-counting reference model of the classification rules.
module tb_treasure_classifier;

    localparam int W = 176, H = 144;
    localparam int K_RED = 0, K_TRI = 1, K_DIAM = 2, K_GREEN = 3, K_TIE = 4, K_RAND = 5;

    logic       CLK = 1'b0;
    logic       RESET, VSYNC, HREF, PIXEL_VALID;
    logic [7:0] PIXEL;
    logic [1:0] TREASURE_COLOR, TREASURE_SHAPE;
    logic       RESULT_VALID;

    int         n_chk = 0, n_err = 0, pulses = 0, fid = 0;
    int         prev_col = 0, prev_shp = 0;
    int         rlen[160];
    int         seed = 0;
    logic [7:0] dom = 8'hE0;
    bit         gaps = 1'b0;

    treasure_classifier dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .VSYNC          (VSYNC),
        .HREF           (HREF),
        .PIXEL_VALID    (PIXEL_VALID),
        .PIXEL          (PIXEL),
        .TREASURE_COLOR (TREASURE_COLOR),
        .TREASURE_SHAPE (TREASURE_SHAPE),
        .RESULT_VALID   (RESULT_VALID)
    );

    always #5 CLK = ~CLK;
    always @(negedge CLK) if (RESULT_VALID === 1'b1) pulses++;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s (frame %0d): got %0d, expected %0d", tag, fid, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int line_len(input int kind, input int y);
        int d;
        case (kind)
            K_RED:   return W;
            K_TRI:   return 89 + y / 2;
            K_DIAM: begin
                d = iabs(y - 72);
                return (d <= 36) ? 100 - (d * 80) / 36 : 0;
            end
            K_GREEN: return 16;
            K_TIE:   return (y >= 50 && y < 90) ? 80 : 0;
            default: return rlen[y];
        endcase
    endfunction

    function automatic logic [7:0] pix_at(input int kind, input int y, input int x);
        int h;
        case (kind)
            K_RED, K_DIAM: return 8'hE0;
            K_TRI:   return (x >= 88 - y / 2) ? 8'h03 : 8'h00;
            K_GREEN: return 8'h1C;
            K_TIE:   return (x < 40) ? 8'hE0 : 8'h03;
            default: begin
                h = (y * 7 + x * 3 + seed) % 8;
                if (h < 5)  return dom;
                if (h == 5) return 8'h1C;
                if (h == 6) return 8'hA1;
                return 8'h42;
            end
        endcase
    endfunction

    // Reference: count classes over the visible window, then apply the decision rules.
    task automatic model(input int kind, input int nl, output int ec, output int es);
        int rc, bc, len, r, b, t, m, bo;
        int wr[3], wbl[3], w[3];
        logic [7:0] p;
        rc = 0; bc = 0;
        for (int i = 0; i < 3; i++) begin wr[i] = 0; wbl[i] = 0; end
        for (int y = 0; y < nl && y < H; y++) begin
            len = line_len(kind, y);
            for (int x = 0; x < len && x < W; x++) begin
                p = pix_at(kind, y, x);
                r = int'(p) / 32;
                b = int'(p) % 4;
                if (r >= 5 && b <= 1) begin
                    rc++;
                    if (y == 36) wr[0]++;
                    if (y == 72) wr[1]++;
                    if (y == 108) wr[2]++;
                end else if (b >= 2 && r <= 2) begin
                    bc++;
                    if (y == 36) wbl[0]++;
                    if (y == 72) wbl[1]++;
                    if (y == 108) wbl[2]++;
                end
            end
        end
        if (rc > 32767) rc = 32767;
        if (bc > 32767) bc = 32767;
        ec = 0;
        w = wr;
        if (rc > bc && rc >= 1000) ec = 2;
        else if (bc >= 1000) begin ec = 3; w = wbl; end
        t = w[0]; m = w[1]; bo = w[2];
        es = 0;
        if (ec == 0 || t == 0 || m == 0 || bo == 0) es = 0;
        else if (iabs(t - bo) <= 4 && iabs(m - t) <= 4) es = 1;
        else if (t + 4 < m && m + 4 < bo) es = 2;
        else if (m > t + 4 && m > bo + 4) es = 3;
    endtask

    task automatic run_frame(input int kind, input int nl, input int rst_row);
        int len;
        VSYNC = 1'b0;
        repeat (3) tick();
        for (int y = 0; y < nl; y++) begin
            if (y == rst_row) begin
                RESET = 1'b1;
                tick();
                tick();
                chk("midrst_col", int'(TREASURE_COLOR), 0);
                chk("midrst_shp", int'(TREASURE_SHAPE), 0);
                chk("midrst_vld", int'(RESULT_VALID), 0);
                prev_col = 0;
                prev_shp = 0;
                RESET = 1'b0;
            end
            len = line_len(kind, y);
            HREF = 1'b1;
            if (len == 0) tick();
            for (int x = 0; x < len; x++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    PIXEL_VALID = 1'b0;
                    PIXEL = 8'($urandom);
                    tick();
                end
                PIXEL = pix_at(kind, y, x);
                PIXEL_VALID = 1'b1;
                tick();
            end
            PIXEL_VALID = 1'b0;
            HREF = 1'b0;
            tick();
            tick();
        end
    endtask

    // Raise VSYNC, track the strobe over a fixed window, then blank with a stray line.
    task automatic close_frame(input bit pub, input int ec, input int es);
        int p0, lat, c, s;
        chk("hold_col", int'(TREASURE_COLOR), prev_col);
        chk("hold_shp", int'(TREASURE_SHAPE), prev_shp);
        p0 = pulses;
        lat = 0; c = 0; s = 0;
        VSYNC = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (RESULT_VALID === 1'b1) lat |= (1 << k);
            if (k == 3) begin c = int'(TREASURE_COLOR); s = int'(TREASURE_SHAPE); end
        end
        HREF = 1'b1; PIXEL = 8'hE0; PIXEL_VALID = 1'b1;
        tick(); tick();
        PIXEL_VALID = 1'b0; HREF = 1'b0;
        tick(); tick();
        if (pub) begin
            chk("latency", lat, 8);
            chk("color", c, ec);
            chk("shape", s, es);
            chk("pulses", pulses - p0, 1);
            prev_col = ec;
            prev_shp = es;
        end else begin
            chk("no_pub_lat", lat, 0);
            chk("no_pub_pulses", pulses - p0, 0);
        end
    endtask

    task automatic do_frame(input int kind, input int nl);
        int ec, es;
        fid++;
        model(kind, nl, ec, es);
        run_frame(kind, nl, -1);
        close_frame(1'b1, ec, es);
    endtask

    initial begin
        logic [7:0] doms [5];
        doms[0] = 8'hE0; doms[1] = 8'h03; doms[2] = 8'h62; doms[3] = 8'hA1; doms[4] = 8'h42;
        RESET = 1'b1; VSYNC = 1'b0; HREF = 1'b0; PIXEL_VALID = 1'b0; PIXEL = 8'h00;
        repeat (3) tick();
        chk("reset_col", int'(TREASURE_COLOR), 0);
        chk("reset_shp", int'(TREASURE_SHAPE), 0);
        chk("reset_vld", int'(RESULT_VALID), 0);
        RESET = 1'b0;
        tick();

        // Partial frame seen after reset must not publish.
        run_frame(K_RED, 20, -1);
        close_frame(1'b0, 0, 0);

        do_frame(K_TRI, 144);
        gaps = 1'b1;
        do_frame(K_DIAM, 144);
        do_frame(K_GREEN, 144);
        do_frame(K_TIE, 144);

        for (int i = 0; i < 3; i++) begin
            seed = int'($urandom_range(0, 1000));
            dom = doms[$urandom_range(0, 4)];
            for (int y = 0; y < 160; y++) rlen[y] = int'($urandom_range(0, 30));
            rlen[36]  = int'($urandom_range(0, 50));
            rlen[72]  = int'($urandom_range(0, 50));
            rlen[108] = int'($urandom_range(0, 50));
            if (i == 1) rlen[$urandom_range(0, 100)] = 185;
            do_frame(K_RAND, int'($urandom_range(110, 150)));
        end

        // Reset in the middle of a frame, then a full red frame.
        fid++;
        gaps = 1'b0;
        run_frame(K_GREEN, 60, 50);
        close_frame(1'b0, 0, 0);
        do_frame(K_RED, 144);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
